// File: rtl/cart_mem_arbiter.sv
// Shared cartridge memory arbiter: queues one mapped PRG and one CHR access,
// grants round-robin onto a req/ack memory port and aborts accesses that never get an ack.
module cart_mem_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        prg_req,
   input  logic [21:0] prg_addr,
   input  logic        prg_we,
   input  logic [7:0]  prg_wdata,
   output logic [7:0]  prg_rdata,
   output logic        prg_done,
   input  logic        chr_req,
   input  logic [21:0] chr_addr,
   input  logic        chr_we,
   input  logic [7:0]  chr_wdata,
   output logic [7:0]  chr_rdata,
   output logic        chr_done,
   output logic        mem_req,
   output logic [21:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        err,
   output logic        overrun
);

   // state | meaning
   // IDLE  | no access on the memory port; grants a pending slot if any
   // BUSY  | mem_req high for the granted port, waiting for ack or timeout
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_next;
   logic        prg_slot_valid, chr_slot_valid;
   logic [21:0] prg_slot_addr, chr_slot_addr;
   logic        prg_slot_we, chr_slot_we;
   logic [7:0]  prg_slot_wdata, chr_slot_wdata;
   logic        grant;        // port in flight: 0 = PRG, 1 = CHR
   logic        last_grant;
   logic [7:0]  tmo_cnt;
   logic        start, pick_chr, complete, timed_out, prg_free, chr_free;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start)    state_next = BUSY;
         BUSY: if (complete) state_next = IDLE;
         default:            state_next = IDLE;
      endcase
   end

   always_comb begin
      start     = 1'b0;
      pick_chr  = 1'b0;
      complete  = 1'b0;
      timed_out = 1'b0;
      case (state)
         IDLE: begin
            start    = prg_slot_valid | chr_slot_valid;
            // CHR wins alone, or on a tie when PRG was served last
            pick_chr = chr_slot_valid & (~prg_slot_valid | ~last_grant);
         end
         BUSY: begin
            complete  = mem_ack | (tmo_cnt == TMO_LAST);
            timed_out = complete & ~mem_ack;
         end
         default: ;
      endcase
      prg_free = complete & ~grant;
      chr_free = complete & grant;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         mem_we         <= 1'b0;
         mem_wdata      <= '0;
         prg_done       <= 1'b0;
         chr_done       <= 1'b0;
         prg_rdata      <= '0;
         chr_rdata      <= '0;
         err            <= 1'b0;
         overrun        <= 1'b0;
         grant          <= 1'b0;
         last_grant     <= 1'b1;
         tmo_cnt        <= '0;
         prg_slot_valid <= 1'b0;
         prg_slot_addr  <= '0;
         prg_slot_we    <= 1'b0;
         prg_slot_wdata <= '0;
         chr_slot_valid <= 1'b0;
         chr_slot_addr  <= '0;
         chr_slot_we    <= 1'b0;
         chr_slot_wdata <= '0;
      end else begin
         prg_done <= prg_free;
         chr_done <= chr_free;

         if (start) begin
            grant      <= pick_chr;
            last_grant <= pick_chr;
            mem_req    <= 1'b1;
            mem_addr   <= pick_chr ? chr_slot_addr  : prg_slot_addr;
            mem_we     <= pick_chr ? chr_slot_we    : prg_slot_we;
            mem_wdata  <= pick_chr ? chr_slot_wdata : prg_slot_wdata;
            tmo_cnt    <= '0;
         end else if (complete) begin
            mem_req <= 1'b0;
         end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end

         if (prg_free & ~mem_we) prg_rdata <= timed_out ? 8'hFF : mem_rdata;
         if (chr_free & ~mem_we) chr_rdata <= timed_out ? 8'hFF : mem_rdata;
         if (timed_out) err <= 1'b1;

         // a request on the completion edge of its own port reuses the freed slot
         if (prg_req & (~prg_slot_valid | prg_free)) begin
            prg_slot_valid <= 1'b1;
            prg_slot_addr  <= prg_addr;
            prg_slot_we    <= prg_we;
            prg_slot_wdata <= prg_wdata;
         end else if (prg_free) begin
            prg_slot_valid <= 1'b0;
         end

         if (chr_req & (~chr_slot_valid | chr_free)) begin
            chr_slot_valid <= 1'b1;
            chr_slot_addr  <= chr_addr;
            chr_slot_we    <= chr_we;
            chr_slot_wdata <= chr_wdata;
         end else if (chr_free) begin
            chr_slot_valid <= 1'b0;
         end

         if ((prg_req & prg_slot_valid & ~prg_free) | (chr_req & chr_slot_valid & ~chr_free))
            overrun <= 1'b1;
      end
   end

endmodule
